// File: rtl/moving_average_pkg.sv
// Shared definitions for the boxcar moving-average filter.
//   acc_width   : width of the running-sum accumulator. It is wide enough
//                 that the sum of LEN full-scale samples (plus the
//                 subtraction of one more) can never overflow.
//   round_shift : divide a running sum by LEN with round-half-up. Half an
//                 LSB of the result is added before the arithmetic shift,
//                 so -0.5 -> 0 and +0.5 -> +1.
package moving_average_pkg;

  // Wide working width for rounding. The caller truncates the result.
  localparam int ROUND_W = 64;

  function automatic int acc_width(input int data_width, input int log2_len);
    return data_width + log2_len + 1;
  endfunction

  function automatic logic signed [ROUND_W-1:0] round_shift(
    input logic signed [ROUND_W-1:0] acc,
    input int unsigned               log2_len
  );
    logic signed [ROUND_W-1:0] half;
    half = 64'sd1 <<< (log2_len - 1);
    return (acc + half) >>> log2_len;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Circular delay line that holds the last LEN = 2**LOG2_LEN samples.
// The read is asynchronous and the write is registered. A read and a write
// at the same pointer in one cycle therefore returns the old contents.
//   clk_i   : clock
//   srst_i  : synchronous active-high reset (clears the pointer and fill count)
//   wr_i    : write data_i at the write pointer, then advance the pointer
//   data_i  : sample to store
//   old_o   : entry at the write pointer (the sample about to leave the window)
//   full_o  : LEN samples have been written since reset, so old_o is real data
import moving_average_pkg::*;

module sample_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_LEN   = 4
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         wr_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] old_o,
  output logic                         full_o
);

  localparam int LEN = 1 << LOG2_LEN;

  logic signed [DATA_WIDTH-1:0] line_q [LEN];
  logic        [LOG2_LEN-1:0]   wptr_q;
  logic        [LOG2_LEN:0]     fill_q;

  assign full_o = (fill_q == (LOG2_LEN + 1)'(LEN));
  assign old_o  = line_q[wptr_q];

  // NOTE: storage has no reset. The fill counter marks stale entries, so
  // clearing the array would only cost reset fan-out and block a RAM mapping.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      line_q[wptr_q] <= data_i;
    end
  end

  // The pointer wraps on its own because LEN is a power of two.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else if (wr_i) begin
      wptr_q <= wptr_q + 1'b1;
      if (!full_o) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar low-pass filter. Each output is the rounded mean of the last
// 2**LOG2_LEN accepted samples. During warm-up the window is zero-padded.
// Pipeline for a sample accepted at edge T:
//   T   : delay line read and write; new and old samples registered
//   T+1 : acc += new - old
//   T+2 : data_o = round(acc / LEN), data_valid_o pulses
//   clk_i          : clock
//   srst_i         : synchronous active-high reset; drops in-flight samples
//   sample_valid_i : single-cycle strobe qualifying data_i
//   data_i         : signed input sample
//   data_o         : signed averaged sample; holds between outputs
//   data_valid_o   : data_o is updated this cycle
import moving_average_pkg::*;

module moving_average_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_LEN   = 4
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         sample_valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_LEN);

  logic signed [DATA_WIDTH-1:0] old_raw;
  logic signed [DATA_WIDTH-1:0] old_masked;
  logic                         line_full;

  logic signed [DATA_WIDTH-1:0] new_q;
  logic signed [DATA_WIDTH-1:0] old_q;
  logic                         stage1_valid_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic                         stage2_valid_q;

  sample_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_LEN   (LOG2_LEN)
  ) u_delay_line (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .wr_i   (sample_valid_i),
    .data_i (data_i),
    .old_o  (old_raw),
    .full_o (line_full)
  );

  // Until the window has filled, the entry leaving it is a zero pad and not
  // whatever the storage happens to hold.
  // NOTE: every variable is given a default before any branch, so no latch
  // can be inferred.
  always_comb begin
    old_masked = '0;
    if (line_full) begin
      old_masked = old_raw;
    end
  end

  // The stage-1 data registers load only on a valid strobe, so idle-cycle
  // garbage on data_i never reaches the accumulator.
  // NOTE: all state uses non-blocking assignments, so each stage reads the
  // previous stage's value from before the edge.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      stage1_valid_q <= 1'b0;
    end else begin
      stage1_valid_q <= sample_valid_i;
    end
    if (sample_valid_i) begin
      new_q <= data_i;
      old_q <= old_masked;
    end
  end

  // Running sum. ACC_W is wide enough for LEN full-scale samples, so this
  // cannot wrap.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q          <= '0;
      stage2_valid_q <= 1'b0;
    end else begin
      stage2_valid_q <= stage1_valid_q;
      if (stage1_valid_q) begin
        acc_q <= acc_q + ACC_W'(new_q) - ACC_W'(old_q);
      end
    end
  end

  // The rounded mean of DATA_WIDTH-bit samples always fits in DATA_WIDTH,
  // so plain truncation is exact.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= stage2_valid_q;
      if (stage2_valid_q) begin
        data_o <= DATA_WIDTH'(round_shift(ROUND_W'(acc_q), LOG2_LEN));
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter with DATA_WIDTH=16, LOG2_LEN=2.
// Stimulus pushes the hand-computed mean and the cycle it is due. A
// negedge monitor pops an entry on every data_valid_o and checks the value
// and the latency. It also flags spurious outputs and missing outputs.
module tb_moving_average_filter;

  localparam int DW = 16;
  localparam int L2 = 2;

  logic                 clk = 1'b0;
  logic                 srst;
  logic                 sample_valid;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] data_out;
  logic                 data_valid;

  always #5 clk = ~clk;

  moving_average_filter #(
    .DATA_WIDTH (DW),
    .LOG2_LEN   (L2)
  ) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .sample_valid_i (sample_valid),
    .data_i         (data_in),
    .data_o         (data_out),
    .data_valid_o   (data_valid)
  );

  typedef struct {
    int value;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: the value and the arrival cycle must both match the head of
  // the queue.
  always @(negedge clk) begin
    exp_t e;
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", data_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("data_o", data_out, e.value);
        check("latency_cycle", cyc, e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      check("missing_valid", data_valid, 1);
    end
  end

  // Inputs change on the falling edge, half a cycle before they are sampled.
  task automatic drive(input logic v, input int d);
    @(negedge clk);
    sample_valid = v;
    data_in      = v ? DW'(d) : 'x;
  endtask

  // A sample accepted on the next rising edge reaches data_o two edges
  // later. The monitor sees it at the negedge where cyc == now + 3.
  task automatic send(input int d, input int expected);
    drive(1'b1, d);
    exp_q.push_back('{expected, cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic drain();
    int budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  // One-cycle reset. A valid strobe may be presented alongside it; that
  // strobe must be ignored.
  task automatic do_reset(input logic with_valid);
    @(negedge clk);
    srst         = 1'b1;
    sample_valid = with_valid;
    data_in      = 16'sd1000;
    @(negedge clk);
    srst         = 1'b0;
    sample_valid = 1'b0;
    data_in      = 'x;
    check("reset_data_o", data_out, 0);
    check("reset_valid", data_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst         = 1'b1;
    sample_valid = 1'b0;
    data_in      = '0;
    repeat (3) @(negedge clk);
    do_reset(1'b1);

    // Step response.
    send(1000, 250);  send(1000, 500);  send(1000, 750);  send(1000, 1000);
    send(1000, 1000); send(1000, 1000); send(1000, 1000); send(1000, 1000);
    drain();
    do_reset(1'b0);

    // Impulse response.
    send(4000, 1000); send(0, 1000); send(0, 1000); send(0, 1000); send(0, 0);
    drain();
    do_reset(1'b0);

    // Rounding: sums -2,-4,-6,-8 then -4,0,4,8.
    send(-2, 0); send(-2, -1); send(-2, -1); send(-2, -2);
    send(2, -1); send(2, 0);   send(2, 1);   send(2, 2);
    drain();
    do_reset(1'b0);

    // Full scale in both directions; the output must never wrap.
    send(32767, 8192);  send(32767, 16384); send(32767, 24575);
    send(32767, 32767); send(32767, 32767);
    send(-32768, 16383);  send(-32768, 0);      send(-32768, -16384);
    send(-32768, -32768); send(-32768, -32768);
    drain();
    do_reset(1'b0);

    // Sparse input: one valid every third cycle.
    send(1000, 250);  idle(2);
    send(2000, 750);  idle(2);
    send(3000, 1500); idle(2);
    send(4000, 2500); idle(2);
    send(5000, 3500); idle(2);
    drain();
    do_reset(1'b0);

    // A sample still in the pipeline when reset hits produces no output.
    drive(1'b1, 1000);
    do_reset(1'b0);
    idle(4);

    // Reset mid-stream, coinciding with a fourth valid. That sample is
    // dropped, and the next sample restarts warm-up.
    send(1000, 250); send(1000, 500); send(1000, 750);
    idle(2);
    do_reset(1'b1);
    send(1000, 250);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moving_average_filter.md
Name: moving_average_filter

Overview:
- Boxcar (moving-average) low-pass stage. It sits directly downstream of the DSP block under test and consumes its sample stream.
- It has the same streaming interface: one data word, qualified by a single-cycle valid strobe.
- Each output is the rounded mean of the last 2**LOG2_LEN accepted samples.
- It uses a circular delay line plus a running-sum accumulator, so cost is O(1) arithmetic per sample.

Parameters:
- DATA_WIDTH, 16: signed sample width, shared by input and output.
- LOG2_LEN, 4: log2 of window length; LEN = 2**LOG2_LEN; legal range 1..8.

Ports:
- clk_i  input  1  system clock, the only clock.
- srst_i  input  1  synchronous, active-high reset.
- sample_valid_i  input  1  data_i is valid this cycle; a single-cycle strobe, legal every cycle.
- data_i  input  DATA_WIDTH  signed input sample.
- data_o  output  DATA_WIDTH  signed averaged sample.
- data_valid_o  output  1  data_o is valid this cycle.

Behaviour:
- One clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values: data_o=0, data_valid_o=0, accumulator=0, write pointer=0, fill counter=0.
  - Delay-line storage is not reset; the fill counter masks stale entries.
- Cycle T, sample_valid_i=1:
  - Read old = line[wptr]; use 0 instead when fill < LEN.
  - Write line[wptr] = data_i.
  - wptr <= wptr+1, wrapping LEN-1 -> 0.
  - fill <= fill+1, saturating at LEN.
- Cycle T+1: acc <= acc + data_i - old, using values registered at T.
  - acc is signed, ACC_WIDTH = DATA_WIDTH+LOG2_LEN+1, so no intermediate overflow is possible.
- Cycle T+2: data_o <= (acc + 2**(LOG2_LEN-1)) >>> LOG2_LEN, truncated to DATA_WIDTH; data_valid_o <= 1.
  - Rounding is round-half-up: -0.5 -> 0, +0.5 -> +1.
  - The result always fits DATA_WIDTH, so no saturation logic is needed.
- Latency: data_valid_o pulses exactly 2 cycles after each sample_valid_i, one output per input.
  - Spacing between outputs equals spacing between inputs; back-to-back inputs give back-to-back outputs.
- sample_valid_i=0: no state changes; data_valid_o=0 two cycles later; data_o holds its last value.
- Warm-up (fill < LEN): the window is zero-padded. Output is sum/LEN, not the partial mean.
- Wrap-around: a read and a write to the same wptr in one cycle return the OLD contents (read-before-write).
- Reset mid-operation: in-flight samples at T+1/T+2 are discarded and no data_valid_o follows.
  - The first sample after reset restarts warm-up.
  - sample_valid_i asserted while srst_i=1 is ignored.
- X on data_i while sample_valid_i=0 must not propagate into acc or data_o.

Decomposition:
- Package moving_average_pkg:
  - function acc_width(data_width, log2_len) returning DATA_WIDTH+LOG2_LEN+1.
  - function round_shift(acc, log2_len) implementing the add-half plus arithmetic shift.
- Sub-module sample_delay_line (circular buffer).
  - Parameters: DATA_WIDTH, LOG2_LEN.
  - Ports: clk_i, srst_i, wr_i, data_i, old_o, full_o.
  - Owns wptr and the fill counter.
  - Maps to registers or distributed RAM; asynchronous read, read-before-write.
- Top level holds the accumulator and output stages.

Test Plan:
All cases use DATA_WIDTH=16, LOG2_LEN=2 (LEN=4), and check latency of 2 cycles on every sample.
- Step: 8 consecutive valid samples of 1000 -> outputs 250, 500, 750, 1000, 1000, 1000, 1000, 1000.
- Impulse: 4000 then 0,0,0,0 -> outputs 1000, 1000, 1000, 1000, 0.
- Rounding: -2 x4 -> 0, -1, -1, -2 (sums -2, -4, -6, -8: -0.5 -> 0, -1.5 -> -1). Then 2 x4 -> -1, 0, 1, 2 (sums -4, 0, 4, 8).
- Full scale: 32767 x5 -> last two outputs 32767; then -32768 x5 -> last output -32768; data_o never wraps.
- Sparse input, valid every 3rd cycle (CLK_PER_SAMPLE style) with 1000, 2000, 3000, 4000, 5000:
  - data_valid_o pulses only 2 cycles after each valid.
  - Outputs: 250, 750, 1500, 2500, 3500.
- Reset mid-stream: 1000 x3, assert srst_i one cycle in the same cycle as a 4th valid, then 1000 x1.
  - No output for the 4th sample.
  - Post-reset output is 250.
